// File: rtl/req_arbiter_if.sv
// Request/grant bundle between requesters and the req_arbiter.
// The master side drives the requests; the slave side (the arbiter) drives the grant.
interface req_arbiter_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic             enable;
    logic             mode;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             valid_bit;

    modport master (
        output enable, mode, req,
        input  grant, grant_idx, valid_bit
    );

    modport slave (
        input  enable, mode, req,
        output grant, grant_idx, valid_bit
    );
endinterface

// File: rtl/req_arbiter.sv
// Registered N-way arbiter: fixed-priority or round-robin selection, grant held while
// requested, forced release after MAX_HOLD cycles when another requester is waiting.
module req_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    req_arbiter_if.slave bus
);
    localparam int               HC_W      = 8;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic [N-1:0]     grant_q;
    logic             valid_q;
    logic [HC_W-1:0]  hold_cnt_q;

    logic [IDX_W-1:0] fix_idx;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] win_idx;
    logic             rr_found;
    logic             rr_take;
    int               rr_cand;
    logic             req_any;
    logic             others_pending;
    logic             release_now;

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] vec;
        vec      = {N{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Winner selection; the RR search starts just below ptr_q and visits ptr_q last.
    always_comb begin
        fix_idx  = {IDX_W{1'b0}};
        rr_idx   = {IDX_W{1'b0}};
        rr_found = 1'b0;
        rr_take  = 1'b0;
        rr_cand  = 0;
        for (int i = 0; i < N; i++) begin
            fix_idx = bus.req[i] ? IDX_W'(i) : fix_idx;
        end
        for (int k = 1; k <= N; k++) begin
            rr_cand  = (int'(ptr_q) + N - k) % N;
            rr_take  = !rr_found && bus.req[rr_cand];
            rr_idx   = rr_take ? IDX_W'(rr_cand) : rr_idx;
            rr_found = rr_found | rr_take;
        end
        win_idx        = bus.mode ? rr_idx : fix_idx;
        req_any        = |bus.req;
        others_pending = |(bus.req & ~grant_q);
        release_now    = !bus.req[grant_idx_q] || !bus.enable ||
                         ((hold_cnt_q == HOLD_LAST) && others_pending);
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PTR_INIT;
            hold_cnt_q  <= {HC_W{1'b0}};
            grant_q     <= {N{1'b0}};
            grant_idx_q <= {IDX_W{1'b0}};
            valid_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    hold_cnt_q <= {HC_W{1'b0}};
                    if (bus.enable && req_any) begin
                        state_q     <= ST_GRANT;
                        ptr_q       <= win_idx;
                        grant_q     <= onehot(win_idx);
                        grant_idx_q <= win_idx;
                        valid_q     <= 1'b1;
                    end else begin
                        grant_q     <= {N{1'b0}};
                        grant_idx_q <= {IDX_W{1'b0}};
                        valid_q     <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state_q     <= ST_IDLE;
                        hold_cnt_q  <= {HC_W{1'b0}};
                        grant_q     <= {N{1'b0}};
                        grant_idx_q <= {IDX_W{1'b0}};
                        valid_q     <= 1'b0;
                    end else if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hold_cnt_q  <= {HC_W{1'b0}};
                    grant_q     <= {N{1'b0}};
                    grant_idx_q <= {IDX_W{1'b0}};
                    valid_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = grant_idx_q;
    assign bus.valid_bit = valid_q;
endmodule

// File: doc/req_arbiter.md
Name: req_arbiter

Overview:
- Registered 8-way arbiter that shares one downstream resource between requesters.
- Bit 7 is the highest static priority, the same ordering as the team's 8:3 priority encoder.
- Supports fixed-priority and round-robin modes, holds a grant while the owner keeps requesting, and force-releases after a hold limit when others are waiting.
- Produces a one-hot grant, an encoded index and a valid flag for the downstream mux/resource.

Parameters:
- N, 8, number of requesters.
- IDX_W, 3, width of Grant_Idx; must equal clog2(N).
- MAX_HOLD, 16, maximum consecutive GRANT cycles for one owner while another request is pending; legal range 2..255.

Ports:
- Clk  input  1  single rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  arbitration enable; low forces release and idle.
- Mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- Req  input  N  request vector, one bit per requester, level-sensitive.
- Grant  output  N  one-hot grant, registered.
- Grant_Idx  output  IDX_W  binary index of the granted requester, registered; 0 when Valid_Bit=0.
- Valid_Bit  output  1  registered; 1 exactly when Grant is nonzero.

Behaviour:
- Reset (async, immediate):
  - Grant=0, Grant_Idx=0, Valid_Bit=0.
  - state=IDLE, Ptr=N-1, Hold_Cnt=0.
- States: IDLE and GRANT.
- IDLE:
  - Grant, Grant_Idx and Valid_Bit are all 0.
  - If Enable=1 and Req!=0, the winner is selected combinationally. On the next edge: Grant=onehot(winner), Grant_Idx=winner, Valid_Bit=1, Ptr=winner, Hold_Cnt=0, state=GRANT.
  - Latency from Req sampled in IDLE to Grant visible is 1 cycle.
  - If Req=0, outputs stay 0. No X is ever driven.
- Winner selection:
  - Mode=0: highest set index of Req.
  - Mode=1: first set bit searching Ptr-1, Ptr-2, ... downward, wrapping from 0 to N-1, with Ptr itself checked last.
  - After reset (Ptr=7), the first RR search order is 6,5,...,0,7.
  - Mode is sampled only in the IDLE arbitration cycle. A change during GRANT has no effect on the current owner.
- GRANT:
  - Outputs hold the owner.
  - Hold_Cnt increments each cycle and saturates at MAX_HOLD-1.
  - Release (next edge: state=IDLE, outputs 0, Hold_Cnt=0) occurs on any of:
    - (a) Req[owner]=0;
    - (b) Enable=0;
    - (c) Hold_Cnt=MAX_HOLD-1 and any other Req bit is set.
  - If no other request is pending, the owner keeps the grant indefinitely with Hold_Cnt saturated.
- Handoff:
  - Every release is followed by at least one all-zero cycle (IDLE) before any new Grant, so owners never overlap.
  - Minimum gap between two grants is 1 cycle.
  - Ptr is retained across release, Enable low and Mode changes. Only Reset reinitialises Ptr.
- Simultaneous events:
  - Release condition (a) and (c) together: a single release; no difference in behaviour.
  - Enable=0 in the same cycle as the IDLE arbitration: no grant is issued.
- Reset mid-GRANT: outputs clear asynchronously in the same cycle. After deassertion, arbitration restarts from IDLE with Ptr=N-1.
- Invariants:
  - Valid_Bit == |Grant.
  - Grant is one-hot or zero.
  - Grant_Idx matches Grant whenever Valid_Bit=1.
  - Outputs change only on Clk edges or Reset.

Test Plan:
- Reset held, then released with Req=0, Enable=1 -> Grant=00000000, Grant_Idx=0, Valid_Bit=0 for 5 cycles.
- Mode=0, Req=8'b01010010 held -> one cycle later Grant=01000000, Grant_Idx=6, Valid_Bit=1. Drop Req[6] -> next cycle all zero. Next cycle Grant=00010000, Idx=4.
- Mode=1, Req=8'b11111111 held constantly, MAX_HOLD=16 -> grants cycle through 6,5,4,3,2,1,0,7,6. Each owner holds exactly 16 cycles, followed by one zero cycle.
- Mode=1, Req=8'b00000100 only, held 100 cycles -> Grant=00000100 stays asserted all 100 cycles, with no forced release.
- Owner 3 granted, Enable driven 0 for one cycle -> next edge outputs 0. With Enable=1 again and Req unchanged, owner regranted per mode. Ptr persists (RR).
- Reset pulsed mid-GRANT of index 5 -> Grant, Idx and Valid_Bit go 0 immediately, without waiting for a Clk edge. The first RR grant after reset starts the search at index 6.
